// File: rtl/cache_wb_ctrl_if.sv
// Bundles the CPU, cache-array and memory-burst control signals of the write-back controller.
// Latency: none, this is wiring only.
// Backpressure: memReady stalls bursts; the controller accepts req only while ready is high.
interface cache_wb_ctrl_if #(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
);
  localparam int BEAT_W = $clog2(WORDS_PER_LINE);

  logic              req;
  logic              we;
  logic              hit;
  logic              dirty;
  logic              memReady;
  logic              clrStats;
  logic              ready;
  logic              done;
  logic              cRead;
  logic              cWrite;
  logic              setDirty;
  logic              clrDirty;
  logic              memRd;
  logic              memWr;
  logic              selOut;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  hitCnt;
  logic [CNT_W-1:0]  missCnt;

  // Controller side.
  modport slave (
    input  req, we, hit, dirty, memReady, clrStats,
    output ready, done, cRead, cWrite, setDirty, clrDirty, memRd, memWr, selOut,
    output beat, hitCnt, missCnt
  );

  // CPU / memory / cache side driving the controller.
  modport master (
    output req, we, hit, dirty, memReady, clrStats,
    input  ready, done, cRead, cWrite, setDirty, clrDirty, memRd, memWr, selOut,
    input  beat, hitCnt, missCnt
  );
endinterface

// File: rtl/cache_wb_ctrl.sv
// Write-back cache controller: lookup, dirty-line writeback burst, refill burst, respond; hit/miss stats.
// Latency: hit 3 cycles accept-to-done, clean miss 3+WORDS_PER_LINE, dirty miss 3+2*WORDS_PER_LINE, plus stalls.
// Backpressure: memReady=0 freezes a burst (state and beat) indefinitely; ready is high only in IDLE.
module cache_wb_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  cache_wb_ctrl_if.slave  bus
);
  localparam int BEAT_W = $clog2(WORDS_PER_LINE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              inc_hit, inc_miss;

  // State, burst beat, latched access type and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      we_q       <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      we_q       <= we_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic and per-state control outputs; beat is only exposed during bursts.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    we_d         = we_q;
    inc_hit      = 1'b0;
    inc_miss     = 1'b0;
    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    bus.cRead    = 1'b0;
    bus.cWrite   = 1'b0;
    bus.setDirty = 1'b0;
    bus.clrDirty = 1'b0;
    bus.memRd    = 1'b0;
    bus.memWr    = 1'b0;
    bus.selOut   = 1'b1;
    bus.beat     = '0;
    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.req) begin
          we_d    = bus.we;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        bus.cRead = 1'b1;
        if (bus.hit) begin
          inc_hit = 1'b1;
          state_d = S_RESPOND;
        end else begin
          inc_miss = 1'b1;
          state_d  = bus.dirty ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        bus.memWr = 1'b1;
        bus.cRead = 1'b1;
        bus.beat  = beat_q;
        if (bus.memReady) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        bus.memRd  = 1'b1;
        bus.selOut = 1'b0;
        bus.cWrite = bus.memReady;
        bus.beat   = beat_q;
        if (bus.memReady) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            bus.clrDirty = 1'b1;
            state_d      = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        bus.done     = 1'b1;
        bus.cWrite   = we_q;
        bus.setDirty = we_q;
        bus.cRead    = ~we_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating statistics; a clear request overrides a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.clrStats) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (inc_hit && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (inc_miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  assign bus.hitCnt  = hit_cnt_q;
  assign bus.missCnt = miss_cnt_q;
endmodule
